fetch_request_unit: RTL and testbench

Instruction-fetch request sequencer sitting directly downstream of `blocking_unit` in the IF stage. It consumes `permit` and `pc`, issues one instruction-memory read per permitted fetch, and holds the address stable until `mem_resp`. It returns the fetched word to the pipeline with a one-cycle `instr_valid` pulse and drives `stall` while a fetch is outstanding. A branch redirect (`flush`) cancels a fetch in flight: the late response is drained and discarded.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_request_unit.sv | 101 ++++++++++
 tb/tb_fetch_request_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Instruction-fetch bus: pipeline-side handshake plus instruction-memory port.
// The fetch_request_unit connects through the slave modport; the driver of
// pc/permit/flush and the memory model use the master modport.
interface fetch_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc;
    logic             permit;
    logic             flush;
    logic             mem_resp;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_read;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             stall;

    modport master (
        output pc, permit, flush, mem_resp, mem_rdata,
        input  mem_read, mem_address, instr, instr_valid, stall
    );

    modport slave (
        input  pc, permit, flush, mem_resp, mem_rdata,
        output mem_read, mem_address, instr, instr_valid, stall
    );
endinterface

// File: rtl/fetch_request_unit.sv
// Instruction-fetch request sequencer (IF stage, after blocking_unit).
// Issues one memory read per permitted fetch, holds the address until the
// response, returns the word with a one-cycle instr_valid pulse, and drains
// responses of fetches cancelled by a redirect.
// Optional feature: define FETCH_LINE_BUF_EN to add a one-entry reuse buffer
// that serves a repeated fetch of the last delivered address without memory.
module fetch_request_unit #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       hit;
    logic       start;
    logic       reuse;
    logic       deliver;

`ifdef FETCH_LINE_BUF_EN
    logic [WIDTH-1:0] buf_tag;
    logic [WIDTH-1:0] buf_data;
    logic             buf_valid;

    assign hit = buf_valid && (bus.pc == buf_tag);
`else
    assign hit = 1'b0;
`endif

    // A fetch goes to memory only when the reuse buffer cannot serve it.
    assign start   = (state == IDLE) && bus.permit && !bus.flush && !hit;
    assign reuse   = (state == IDLE) && bus.permit && !bus.flush && hit;
    assign deliver = (state == BUSY) && bus.mem_resp && !bus.flush;

    // The PC must hold while a fetch is outstanding or about to be issued.
    assign bus.stall = (state != IDLE) || start;

    // Next-state decode; responses seen in IDLE are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY: begin
                if (bus.mem_resp)   state_nxt = IDLE;
                else if (bus.flush) state_nxt = DRAIN;
            end
            DRAIN:   if (bus.mem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, request and delivery registers; mem_read is a flop, not a decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.mem_read    <= 1'b0;
            bus.mem_address <= '0;
            bus.instr       <= '0;
            bus.instr_valid <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.mem_read    <= (state_nxt != IDLE);
            bus.instr_valid <= deliver || reuse;
            if (start) begin
                bus.mem_address <= bus.pc;
            end
            if (deliver) begin
                bus.instr <= bus.mem_rdata;
            end
`ifdef FETCH_LINE_BUF_EN
            else if (reuse) begin
                bus.instr <= buf_data;
            end
`endif
        end
    end

`ifdef FETCH_LINE_BUF_EN
    // Buffer valid bit: set by the first delivery, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (deliver) begin
            buf_valid <= 1'b1;
        end
    end

    // Buffer tag and data follow every non-discarded delivery.
    always_ff @(posedge clk) begin
        if (deliver) begin
            buf_tag  <= bus.mem_address;
            buf_data <= bus.mem_rdata;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed bench for fetch_request_unit. Delivered words are checked through
// a scoreboard queue; control outputs are checked at each directed step.
module tb_fetch_request_unit;
    logic clk;
    logic rst;

    fetch_if #(.WIDTH(32)) bus ();

    fetch_request_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          valid_seen  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard: every instr_valid pulse pops one expected word.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid === 1'b1) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                check_bit("unexpected_instr_valid", 1'b1, 1'b0);
            end else begin
                check("instr_word", bus.instr, exp_q.pop_front());
            end
        end
    end

    initial begin
        int vs;
        rst           = 1'b1;
        bus.pc        = '0;
        bus.permit    = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        cur_instr     = '0;

        // Reset state
        tick(); tick();
        sample();
        check_bit("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check_bit("rst_instr_valid", bus.instr_valid, 1'b0);
        check_bit("rst_stall", bus.stall, 1'b0);
        tick();
        rst = 1'b0;

        // Basic fetch, response two cycles after mem_read rises
        vs = valid_seen;
        bus.pc = 32'h60; bus.permit = 1'b1;
        sample();
        check_bit("basic_stall_idle", bus.stall, 1'b1);
        check_bit("basic_no_read_yet", bus.mem_read, 1'b0);
        tick();
        bus.permit = 1'b0;
        sample();
        check_bit("basic_mem_read", bus.mem_read, 1'b1);
        check("basic_mem_address", bus.mem_address, 32'h60);
        tick();
        sample();
        check_bit("basic_read_held", bus.mem_read, 1'b1);
        tick();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00A00093;
        exp_q.push_back(32'h00A00093);
        sample();
        check_bit("basic_no_early_valid", bus.instr_valid, 1'b0);
        tick();
        bus.mem_resp = 1'b0; bus.mem_rdata = 32'h0;
        sample();
        check_bit("basic_valid", bus.instr_valid, 1'b1);
        check_bit("basic_read_drop", bus.mem_read, 1'b0);
        check_bit("basic_idle_stall", bus.stall, 1'b0);
        tick();
        sample();
        check_bit("basic_valid_one_cycle", bus.instr_valid, 1'b0);
        check("basic_pulse_count", 32'(valid_seen - vs), 32'd1);
        cur_instr = 32'h00A00093;

        // Zero-wait memory, then a new request in the instr_valid cycle
        tick();
        bus.pc = 32'h64; bus.permit = 1'b1;
        sample();
        check_bit("zw_stall_c1", bus.stall, 1'b1);
        tick();
        bus.permit = 1'b0; bus.mem_resp = 1'b1; bus.mem_rdata = 32'h11111111;
        exp_q.push_back(32'h11111111);
        sample();
        check_bit("zw_stall_c2", bus.stall, 1'b1);
        check_bit("zw_mem_read", bus.mem_read, 1'b1);
        tick();
        bus.mem_resp = 1'b0;
        sample();
        check_bit("zw_valid", bus.instr_valid, 1'b1);
        check_bit("zw_stall_c3", bus.stall, 1'b0);
        cur_instr = 32'h11111111;
        bus.pc = 32'h68; bus.permit = 1'b1;
        #1;
        check_bit("b2b_stall", bus.stall, 1'b1);
        tick();
        bus.permit = 1'b0;
        sample();
        check_bit("b2b_mem_read", bus.mem_read, 1'b1);
        check("b2b_mem_address", bus.mem_address, 32'h68);
        tick();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h22220013;
        exp_q.push_back(32'h22220013);
        tick();
        bus.mem_resp = 1'b0;
        sample();
        cur_instr = 32'h22220013;
        tick();

        // Flush in BUSY; second flush in DRAIN has no effect
        vs = valid_seen;
        bus.pc = 32'h80; bus.permit = 1'b1;
        tick();
        bus.permit = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        sample();
        check_bit("drain_mem_read", bus.mem_read, 1'b1);
        check("drain_mem_address", bus.mem_address, 32'h80);
        check_bit("drain_stall", bus.stall, 1'b1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.mem_resp = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        sample();
        check_bit("drain_read_at_resp", bus.mem_read, 1'b1);
        tick();
        bus.mem_resp = 1'b0;
        sample();
        check_bit("drain_done_read", bus.mem_read, 1'b0);
        check("drain_instr_kept", bus.instr, cur_instr);
        check_bit("drain_no_valid", bus.instr_valid, 1'b0);
        check_bit("drain_idle", bus.stall, 1'b0);

        // Flush coincident with mem_resp
        tick();
        bus.pc = 32'h90; bus.permit = 1'b1;
        tick();
        bus.permit = 1'b0;
        tick();
        bus.flush = 1'b1; bus.mem_resp = 1'b1; bus.mem_rdata = 32'h33333333;
        tick();
        bus.flush = 1'b0; bus.mem_resp = 1'b0;
        sample();
        check_bit("coinc_mem_read", bus.mem_read, 1'b0);
        check_bit("coinc_no_valid", bus.instr_valid, 1'b0);
        check_bit("coinc_idle", bus.stall, 1'b0);
        check("coinc_instr_kept", bus.instr, cur_instr);
        check("flush_pulses", 32'(valid_seen - vs), 32'd0);

        // Flush beats permit in IDLE; mem_resp ignored in IDLE
        tick();
        bus.pc = 32'hA0; bus.permit = 1'b1; bus.flush = 1'b1;
        sample();
        check_bit("flush_wins_stall", bus.stall, 1'b0);
        tick();
        bus.permit = 1'b0; bus.flush = 1'b0;
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h44444444;
        sample();
        check_bit("flush_wins_no_read", bus.mem_read, 1'b0);
        tick();
        bus.mem_resp = 1'b0;
        sample();
        check("idle_resp_ignored", bus.instr, cur_instr);
        check_bit("idle_resp_no_read", bus.mem_read, 1'b0);

        // Repeat fetch of the last delivered address
        tick();
        vs = valid_seen;
        bus.pc = 32'h68; bus.permit = 1'b1;
`ifdef FETCH_LINE_BUF_EN
        exp_q.push_back(32'h22220013);
        sample();
        check_bit("reuse_no_stall", bus.stall, 1'b0);
        tick();
        bus.permit = 1'b0;
        sample();
        check_bit("reuse_no_mem_read", bus.mem_read, 1'b0);
        check_bit("reuse_valid", bus.instr_valid, 1'b1);
`else
        sample();
        check_bit("refetch_stall", bus.stall, 1'b1);
        tick();
        bus.permit = 1'b0; bus.mem_resp = 1'b1; bus.mem_rdata = 32'h55555555;
        exp_q.push_back(32'h55555555);
        sample();
        check_bit("refetch_mem_read", bus.mem_read, 1'b1);
        tick();
        bus.mem_resp = 1'b0;
        sample();
        check_bit("refetch_valid", bus.instr_valid, 1'b1);
`endif
        tick();
        sample();
        check("refetch_pulses", 32'(valid_seen - vs), 32'd1);

        // Asynchronous reset mid-BUSY
        tick();
        bus.pc = 32'hC0; bus.permit = 1'b1;
        tick();
        bus.permit = 1'b0;
        #1;
        check_bit("pre_rst_busy", bus.mem_read, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("arst_mem_read", bus.mem_read, 1'b0);
        check("arst_mem_address", bus.mem_address, 32'h0);
        check("arst_instr", bus.instr, 32'h0);
        check_bit("arst_instr_valid", bus.instr_valid, 1'b0);
        check_bit("arst_stall", bus.stall, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        sample();
        check_bit("post_rst_idle", bus.mem_read, 1'b0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
